// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and transmitter.
package uart_pkg;

  localparam int unsigned UART_SAMPLES_PER_BIT = 16;
  localparam int unsigned UART_DATA_BITS       = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial input; resets to the idle (mark) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], din};
    end
  end

  assign dout = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, oversampled with majority vote at mid-bit, valid/ready output.
// Define UART_RX_SYNC_EN to pass serial_data through a 2-flop synchronizer.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_BIT = UART_SAMPLES_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample_trigger,
  input  logic                      serial_data,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      framing_error,
  output logic                      overrun
);

  localparam int unsigned CntW = $clog2(SAMPLES_PER_BIT);
  localparam int unsigned IdxW = $clog2(UART_DATA_BITS);
  localparam logic [CntW-1:0] VotePt  = CntW'(SAMPLES_PER_BIT / 2 + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(SAMPLES_PER_BIT - 1);
  localparam logic [IdxW-1:0] LastBit = IdxW'(UART_DATA_BITS - 1);

  logic line;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (serial_data),
    .dout  (line)
  );
`else
  assign line = serial_data;
`endif

  uart_rx_state_t            state_q, state_d;
  logic [CntW-1:0]           scnt_q, scnt_d;
  logic [IdxW-1:0]           bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic [1:0]                hist_q, hist_d;
  logic                      valid_q, valid_d;
  logic                      fe_q, fe_d;
  logic                      ov_q, ov_d;
  logic                      vote, at_vote, at_last, load;

  // hist_q holds the samples from the two previous triggers (scnt V-2, V-1 at the vote point)
  assign vote    = (hist_q[1] & hist_q[0]) | (hist_q[1] & line) | (hist_q[0] & line);
  assign at_vote = (scnt_q == VotePt);
  assign at_last = (scnt_q == LastCnt);

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    hist_d    = hist_q;
    load      = 1'b0;
    fe_d      = 1'b0;
    ov_d      = 1'b0;

    if (sample_trigger) begin
      hist_d = {hist_q[0], line};
      unique case (state_q)
        IDLE: begin
          if (!line) begin
            scnt_d  = CntW'(1);
            state_d = START;
          end
        end
        START: begin
          if (at_vote && vote) begin
            scnt_d  = '0;
            state_d = IDLE;
          end else if (at_last) begin
            scnt_d    = '0;
            bit_idx_d = '0;
            state_d   = DATA;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        DATA: begin
          if (at_vote) begin
            shift_d = {vote, shift_q[UART_DATA_BITS-1:1]};
          end
          if (at_last) begin
            scnt_d = '0;
            if (bit_idx_q == LastBit) begin
              state_d = STOP;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        STOP: begin
          // Leave at mid-stop so the next start edge is caught despite clock skew
          if (at_vote) begin
            scnt_d = '0;
            if (vote) begin
              state_d = IDLE;
              if (!valid_q || ready) begin
                load = 1'b1;
              end else begin
                ov_d = 1'b1;
              end
            end else begin
              state_d = WAIT_IDLE;
              fe_d    = 1'b1;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (line) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (load) begin
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    data_d = load ? shift_q : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      scnt_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      hist_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      hist_q    <= hist_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  assign data          = data_q;
  assign valid         = valid_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of good frames plus hand-written corner sequences.
module tb_uart_rx;

  localparam int SPB  = 16;
  localparam int VOTE = SPB / 2 + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_trigger = 1'b0;
  logic       serial_data = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int acc_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] b;
    int         flip_bit;
    int         flip_samp;
    bit         lat;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  uart_rx #(.SAMPLES_PER_BIT(SPB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sample_trigger (sample_trigger),
    .serial_data    (serial_data),
    .data           (data),
    .valid          (valid),
    .ready          (ready),
    .framing_error  (framing_error),
    .overrun        (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on negedge; monitor looks #1 later, so valid&&ready means acceptance
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (valid && ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'h0, data}, 32'hffff_ffff);
        end else begin
          check("rx_byte", {24'h0, data}, {24'h0, exp_q.pop_front()});
        end
      end
      if (framing_error) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  task automatic tick_obs(input logic line, output logic v_pre, output logic v_post);
    @(negedge clk);
    v_pre          = valid;
    serial_data    = line;
    sample_trigger = 1'b1;
    @(posedge clk);
    #1 v_post = valid;
    @(negedge clk);
    sample_trigger = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic tick(input logic line);
    logic a, b;
    tick_obs(line, a, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int flip_bit,
                            input int flip_samp, input bit lat);
    logic v, pre, post;
    for (int k = 0; k < 10; k++) begin
      for (int s = 0; s < SPB; s++) begin
        if (k == 0) v = 1'b0;
        else if (k == 9) v = stop;
        else v = b[k-1];
        if (k - 1 == flip_bit && s == flip_samp) v = ~v;
        tick_obs(v, pre, post);
        if (lat && k == 9 && s == VOTE) begin
          check("lat_pre_vote", {31'h0, pre}, 32'h0);
          check("lat_post_vote", {31'h0, post}, 32'h1);
        end
      end
    end
  endtask

  initial begin
    int fe0, ov0, a0;
    vecs[0] = '{b: 8'hA5, flip_bit: -1, flip_samp: -1, lat: 1'b1};
    vecs[1] = '{b: 8'hF0, flip_bit: 4,  flip_samp: 8,  lat: 1'b0};
    vecs[2] = '{b: 8'h00, flip_bit: -1, flip_samp: -1, lat: 1'b0};
    vecs[3] = '{b: 8'hFF, flip_bit: 0,  flip_samp: 7,  lat: 1'b0};
    vecs[4] = '{b: 8'h5A, flip_bit: 7,  flip_samp: 9,  lat: 1'b0};

    repeat (3) @(negedge clk);
    check("rst_data", {24'h0, data}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_fe", {31'h0, framing_error}, 32'h0);
    check("rst_ov", {31'h0, overrun}, 32'h0);
    rst_n = 1'b1;
    idle(3);
    check("idle_valid", {31'h0, valid}, 32'h0);

    // Good frames, consumer always ready
    for (int i = 0; i < 5; i++) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      exp_q.push_back(vecs[i].b);
      send_frame(vecs[i].b, 1'b1, vecs[i].flip_bit, vecs[i].flip_samp, vecs[i].lat);
      idle(4);
      check("tbl_fe", fe_cnt - fe0, 0);
      check("tbl_ov", ov_cnt - ov0, 0);
      check("tbl_drained", exp_q.size(), 0);
    end

    // Start-bit glitch, then a good byte
    fe0 = fe_cnt; ov0 = ov_cnt; a0 = acc_cnt;
    repeat (3) tick(1'b0);
    idle(20);
    check("glitch_novalid", acc_cnt - a0, 0);
    check("glitch_fe", fe_cnt - fe0, 0);
    check("glitch_ov", ov_cnt - ov0, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, -1, -1, 1'b0);
    idle(4);
    check("glitch_next_rx", exp_q.size(), 0);

    // Bad stop bit followed by a break, then a good byte
    fe0 = fe_cnt; ov0 = ov_cnt; a0 = acc_cnt;
    send_frame(8'h55, 1'b0, -1, -1, 1'b0);
    repeat (40) tick(1'b0);
    idle(4);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1, -1, 1'b0);
    idle(4);
    check("break_fe_once", fe_cnt - fe0, 1);
    check("break_ov", ov_cnt - ov0, 0);
    check("break_acc", acc_cnt - a0, 1);
    check("break_drained", exp_q.size(), 0);

    // Overrun: consumer stalled across two back-to-back frames
    @(negedge clk);
    ready = 1'b0;
    fe0 = fe_cnt; ov0 = ov_cnt; a0 = acc_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1, -1, 1'b0);
    send_frame(8'h22, 1'b1, -1, -1, 1'b0);
    idle(4);
    check("ovr_valid_held", {31'h0, valid}, 32'h1);
    check("ovr_data_held", {24'h0, data}, 32'h11);
    check("ovr_pulse", ov_cnt - ov0, 1);
    check("ovr_fe", fe_cnt - fe0, 0);
    check("ovr_no_acc", acc_cnt - a0, 0);
    @(negedge clk);
    ready = 1'b1;
    repeat (3) @(negedge clk);
    check("ovr_consumed", acc_cnt - a0, 1);
    check("ovr_valid_drop", {31'h0, valid}, 32'h0);
    check("ovr_drained", exp_q.size(), 0);

    // Reset in data bit 4 of 8'h7E
    fe0 = fe_cnt;
    repeat (SPB) tick(1'b0);
    for (int k = 0; k < 4; k++) repeat (SPB) tick(k == 0 ? 1'b0 : 1'b1);
    repeat (5) tick(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", {24'h0, data}, 32'h0);
    check("mid_rst_valid", {31'h0, valid}, 32'h0);
    check("mid_rst_fe", {31'h0, framing_error}, 32'h0);
    check("mid_rst_ov", {31'h0, overrun}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, -1, -1, 1'b0);
    idle(4);
    check("post_rst_rx", exp_q.size(), 0);
    check("post_rst_fe", fe_cnt - fe0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
